// File: rtl/maxsonar_pkg.sv
// Shared types and default timing for the PmodMAXSONAR ranging controller.
// Defaults are derived from a 100 MHz system clock.
package maxsonar_pkg;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int CLK_PER_US  = CLK_FREQ_HZ / 1_000_000;

  localparam int DEF_CLKS_PER_INCH  = 147 * CLK_PER_US;     // 147 us per inch
  localparam int DEF_TRIG_CYCLES    = 25 * CLK_PER_US;      // 25 us trigger
  localparam int DEF_TIMEOUT_CYCLES = 50_000 * CLK_PER_US;  // 50 ms
  localparam int DEF_HOLDOFF_CYCLES = 50_000 * CLK_PER_US;  // 50 ms
  localparam int DEF_RANGE_W        = 9;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_HI,
    MEASURE,
    DONE,
    HOLD
  } state_t;

  // Bits needed to count 0..terminal-1; never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/maxsonar_sync_edge.sv
// Brings the asynchronous sensor PWM into the clk domain and flags its edges.
// Both edges see the same three-register latency, so pulse width is preserved.
module maxsonar_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  // NOTE: registers use non-blocking assignments so every stage samples the
  // value from before the clock edge, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign rise = sync & ~dly;
  assign fall = ~sync & dly;

endmodule

// File: rtl/pmod_maxsonar_ctrl.sv
// PmodMAXSONAR ranging controller: triggers the sensor on rx, times the PWM echo
// pulse and hands the range in inches to the consumer over valid/ready.
module pmod_maxsonar_ctrl
  import maxsonar_pkg::*;
#(
  parameter int CLKS_PER_INCH  = DEF_CLKS_PER_INCH,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int RANGE_W        = DEF_RANGE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               continuous,
  input  logic               pwm,
  output logic               rx,
  output logic               busy,
  output logic [RANGE_W-1:0] range_inches,
  output logic               range_err,
  output logic               range_valid,
  input  logic               range_ready
);

  localparam int CNT_W = cnt_width(max3(TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES));
  localparam int PRE_W = cnt_width(CLKS_PER_INCH);

  localparam logic [CNT_W-1:0]   TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST     = PRE_W'(CLKS_PER_INCH - 1);
  localparam logic [RANGE_W-1:0] INCH_MAX     = '1;

  state_t state;
  state_t state_next;

  logic               pwm_rise;
  logic               pwm_fall;
  logic [CNT_W-1:0]   cnt;
  logic [PRE_W-1:0]   presc;
  logic [RANGE_W-1:0] inch;
  logic [RANGE_W-1:0] inch_step;
  logic               pre_wrap;
  logic               load_range;
  logic               load_err;
  logic [RANGE_W-1:0] range_q;
  logic               err_q;

  maxsonar_sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm),
    .rise (pwm_rise),
    .fall (pwm_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load_range = 1'b0;
    load_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start || continuous) state_next = TRIG;
      end
      TRIG: begin
        if (cnt == TRIG_LAST) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (pwm_rise) begin
          state_next = MEASURE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = DONE;
          load_err   = 1'b1;
        end
      end
      MEASURE: begin
        // A falling edge on the last allowed cycle still counts as a valid echo.
        if (pwm_fall) begin
          state_next = DONE;
          load_range = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = DONE;
          load_err   = 1'b1;
        end
      end
      DONE: begin
        if (range_ready) state_next = continuous ? HOLD : IDLE;
      end
      HOLD: begin
        if (!continuous)            state_next = IDLE;
        else if (cnt == HOLD_LAST)  state_next = TRIG;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx          = (state == TRIG);
    busy        = (state != IDLE);
    range_valid = (state == DONE);
  end

  // One cycle counter serves TRIG, WAIT_HI, MEASURE and HOLD; it restarts on
  // every state change so each state times itself from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_next != state) || (state == IDLE) || (state == DONE)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign pre_wrap  = (presc == PRE_LAST);
  assign inch_step = (pre_wrap && (inch != INCH_MAX)) ? inch + RANGE_W'(1) : inch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      inch  <= '0;
    end else if (state == MEASURE) begin
      presc <= pre_wrap ? '0 : presc + PRE_W'(1);
      inch  <= inch_step;
    end else begin
      presc <= '0;
      inch  <= '0;
    end
  end

  // The result includes the inch completed on the falling-edge cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_q <= '0;
      err_q   <= 1'b0;
    end else if (load_range) begin
      range_q <= inch_step;
      err_q   <= 1'b0;
    end else if (load_err) begin
      range_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign range_inches = range_q;
  assign range_err    = err_q;

  result_held: assert property (@(posedge clk) disable iff (rst)
    (range_valid && !range_ready) |=> (range_valid && $stable(range_inches) && $stable(range_err)));

  trigger_only_when_busy: assert property (@(posedge clk) disable iff (rst)
    rx |-> busy);

endmodule

// File: tb/tb_pmod_maxsonar_ctrl.sv
// Bench for pmod_maxsonar_ctrl with scaled timing; a second instance with a
// narrow range output exercises inch-counter saturation on the same stimulus.
module tb_pmod_maxsonar_ctrl;

  localparam int CPI     = 10;
  localparam int TRIG    = 5;
  localparam int TMO     = 1000;
  localparam int HOLDOFF = 50;
  localparam int RW      = 9;
  localparam int RW_S    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic pwm = 1'b0;
  logic range_ready = 1'b0;

  logic            rx, busy, range_err, range_valid;
  logic [RW-1:0]   range_inches;
  logic            rx_s, busy_s, err_s, valid_s;
  logic [RW_S-1:0] range_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  pmod_maxsonar_ctrl #(
    .CLKS_PER_INCH(CPI), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLDOFF), .RANGE_W(RW)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .pwm(pwm),
    .rx(rx), .busy(busy), .range_inches(range_inches), .range_err(range_err),
    .range_valid(range_valid), .range_ready(range_ready)
  );

  pmod_maxsonar_ctrl #(
    .CLKS_PER_INCH(CPI), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLDOFF), .RANGE_W(RW_S)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .pwm(pwm),
    .rx(rx_s), .busy(busy_s), .range_inches(range_s), .range_err(err_s),
    .range_valid(valid_s), .range_ready(range_ready)
  );

  // Reference model: a pulse of width clocks is width/CPI whole inches,
  // clipped to the output range; anything longer than the timeout is an error.
  function automatic int exp_range(input int width, input int rw);
    int inches;
    int cap;
    inches = width / CPI;
    cap    = (1 << rw) - 1;
    if (width > TMO) return 0;
    return (inches > cap) ? cap : inches;
  endfunction

  function automatic bit exp_err(input int width);
    return width > TMO;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rx) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic trig_window(output int len);
    len = 0;
    while (rx && len < 100) begin
      len++;
      tick();
    end
  endtask

  task automatic send_pulse(input int delay, input int width);
    repeat (delay) tick();
    pwm = 1'b1;
    repeat (width) tick();
    pwm = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int waited;
    waited = 0;
    while (!range_valid && waited < budget) begin
      tick();
      waited++;
    end
    ok = range_valid;
  endtask

  task automatic measure(input int delay, input int width, output int len, output bit ok);
    bit got_rx;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx(got_rx);
    trig_window(len);
    if (!got_rx) len = -1;
    send_pulse(delay, width);
    wait_valid(2000, ok);
  endtask

  task automatic handshake();
    range_ready = 1'b1;
    tick();
    range_ready = 1'b0;
  endtask

  task automatic test_measurement(input string tag, input int delay, input int width);
    int len;
    bit ok;
    measure(delay, width, len, ok);
    n_checks++;
    if (len !== TRIG) begin
      n_fail++;
      $display("FAIL %s rx_high: got %0d clk, expected %0d", tag, len, TRIG);
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid_timeout: range_valid never rose (width %0d)", tag, width);
    end
    n_checks++;
    if (range_inches !== RW'(exp_range(width, RW)) || range_err !== exp_err(width)) begin
      n_fail++;
      $display("FAIL %s result: width %0d got range %0d err %0b, expected range %0d err %0b",
               tag, width, range_inches, range_err, exp_range(width, RW), exp_err(width));
    end
    n_checks++;
    if (range_s !== RW_S'(exp_range(width, RW_S)) || err_s !== exp_err(width)) begin
      n_fail++;
      $display("FAIL %s result_narrow: width %0d got range %0d err %0b, expected range %0d err %0b",
               tag, width, range_s, err_s, exp_range(width, RW_S), exp_err(width));
    end
    handshake();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({rx, busy, range_valid, range_err} !== 4'b0000 || range_inches !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rx %b busy %b valid %b err %b range %0d, expected all 0",
               rx, busy, range_valid, range_err, range_inches);
    end
    n_checks++;
    if ({rx_s, busy_s, valid_s, err_s} !== 4'b0000 || range_s !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_narrow: rx %b busy %b valid %b err %b range %0d, expected all 0",
               rx_s, busy_s, valid_s, err_s, range_s);
    end
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || rx !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy %b rx %b, expected 0 0", busy, rx);
    end
  endtask

  task automatic test_single();
    int len;
    bit ok;
    bit held;
    logic [RW-1:0] r;
    measure(20, 125, len, ok);
    n_checks++;
    if (len !== TRIG) begin
      n_fail++;
      $display("FAIL single rx_high: got %0d clk, expected %0d", len, TRIG);
    end
    n_checks++;
    if (ok !== 1'b1 || range_inches !== RW'(12) || range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single result: valid %b range %0d err %b, expected 1 12 0",
               range_valid, range_inches, range_err);
    end
    held = 1'b1;
    r = range_inches;
    for (int i = 0; i < 20; i++) begin
      if (!range_valid || range_inches !== r || range_err) held = 1'b0;
      tick();
    end
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL single hold: result changed while ready low, got %0b expected 1", held);
    end
    handshake();
    n_checks++;
    if (range_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single after_handshake: valid %b busy %b, expected 0 0", range_valid, busy);
    end
  endtask

  task automatic test_no_echo();
    int len;
    bit got_rx;
    bit early;
    early = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx(got_rx);
    trig_window(len);
    for (int i = 0; i < TMO; i++) begin
      if (range_valid) early = 1'b1;
      tick();
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL no_echo early_valid: valid before %0d clk, expected none", TMO);
    end
    n_checks++;
    if (range_valid !== 1'b1 || range_err !== 1'b1 || range_inches !== '0) begin
      n_fail++;
      $display("FAIL no_echo timeout: valid %b err %b range %0d, expected 1 1 0",
               range_valid, range_err, range_inches);
    end
    handshake();
  endtask

  task automatic test_long_pulse();
    int len;
    bit got_rx;
    bit early;
    bit held;
    early = 1'b0;
    held  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx(got_rx);
    trig_window(len);
    repeat (10) tick();
    pwm = 1'b1;
    // 3 clk edge latency plus the full timeout before the error is posted.
    for (int i = 0; i < TMO + 3; i++) begin
      if (range_valid) early = 1'b1;
      tick();
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL long_pulse early_valid: valid before %0d clk, expected none", TMO + 3);
    end
    n_checks++;
    if (range_valid !== 1'b1 || range_err !== 1'b1 || range_inches !== '0 ||
        valid_s !== 1'b1 || err_s !== 1'b1) begin
      n_fail++;
      $display("FAIL long_pulse timeout: valid %b err %b range %0d, expected 1 1 0",
               range_valid, range_err, range_inches);
    end
    for (int i = TMO + 3; i < 6000; i++) begin
      if (!range_valid || !range_err || range_inches !== '0) held = 1'b0;
      tick();
    end
    pwm = 1'b0;
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL long_pulse hold: error result not held, got %0b expected 1", held);
    end
    repeat (5) tick();
    handshake();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL long_pulse idle: busy %b, expected 0", busy);
    end
  endtask

  task automatic test_boundaries();
    int widths[5] = '{1, 10, 900, 1000, 1001};
    foreach (widths[i]) test_measurement("boundary", $urandom_range(0, 20), widths[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      test_measurement("random", $urandom_range(0, 100), $urandom_range(1, 1000));
  endtask

  task automatic test_continuous();
    int len;
    bit ok;
    bit quiet;
    int hs_cyc;
    int w;
    hs_cyc = 0;
    quiet  = 1'b1;
    range_ready = 1'b1;
    continuous  = 1'b1;
    for (int it = 0; it < 3; it++) begin
      wait_rx(ok);
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL continuous retrigger: no rx pulse in round %0d", it);
      end
      if (it > 0) begin
        n_checks++;
        if (cyc - hs_cyc !== HOLDOFF + 1) begin
          n_fail++;
          $display("FAIL continuous holdoff: trigger %0d clk after handshake, expected %0d",
                   cyc - hs_cyc - 1, HOLDOFF);
        end
      end
      trig_window(len);
      w = $urandom_range(20, 400);
      send_pulse($urandom_range(0, 50), w);
      wait_valid(100, ok);
      hs_cyc = cyc;
      n_checks++;
      if (ok !== 1'b1 || range_inches !== RW'(exp_range(w, RW)) || range_err !== 1'b0) begin
        n_fail++;
        $display("FAIL continuous result: width %0d got valid %b range %0d err %b, expected 1 %0d 0",
                 w, range_valid, range_inches, range_err, exp_range(w, RW));
      end
    end
    repeat (10) tick();
    continuous = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL continuous drop: busy %b after leaving continuous in holdoff, expected 0", busy);
    end
    for (int i = 0; i < 100; i++) begin
      if (rx || busy) quiet = 1'b0;
      tick();
    end
    range_ready = 1'b0;
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL continuous quiet: activity after drop, got %0b expected 1", quiet);
    end
  endtask

  task automatic test_stall();
    int len;
    bit ok;
    bit stable;
    int w;
    logic [RW-1:0] held_range;
    stable = 1'b1;
    range_ready = 1'b0;
    continuous  = 1'b1;
    wait_rx(ok);
    trig_window(len);
    w = $urandom_range(100, 800);
    send_pulse($urandom_range(0, 30), w);
    wait_valid(100, ok);
    n_checks++;
    if (ok !== 1'b1 || range_inches !== RW'(exp_range(w, RW))) begin
      n_fail++;
      $display("FAIL stall result: width %0d got valid %b range %0d, expected 1 %0d",
               w, range_valid, range_inches, exp_range(w, RW));
    end
    held_range = range_inches;
    for (int i = 0; i < 300; i++) begin
      if (rx || !range_valid || range_inches !== held_range) stable = 1'b0;
      tick();
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL stall hold: retrigger or result change while ready low, got %0b expected 1", stable);
    end
    continuous  = 1'b0;
    range_ready = 1'b1;
    tick();
    range_ready = 1'b0;
    n_checks++;
    if (range_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall release: valid %b busy %b, expected 0 0", range_valid, busy);
    end
  endtask

  task automatic test_start_ignored();
    int len;
    bit ok;
    bit quiet;
    int w;
    quiet = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx(ok);
    trig_window(len);
    w = $urandom_range(100, 300);
    repeat (3) tick();
    pwm = 1'b1;
    for (int i = 0; i < w; i++) begin
      start = ((i % 23) == 7);
      tick();
    end
    start = 1'b0;
    pwm   = 1'b0;
    wait_valid(100, ok);
    n_checks++;
    if (ok !== 1'b1 || range_inches !== RW'(exp_range(w, RW)) || range_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored result: width %0d got valid %b range %0d err %b, expected 1 %0d 0",
               w, range_valid, range_inches, range_err, exp_range(w, RW));
    end
    handshake();
    for (int i = 0; i < 200; i++) begin
      if (rx || busy) quiet = 1'b0;
      tick();
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored queued: a second measurement ran, got %0b expected 1", quiet);
    end
  endtask

  task automatic test_reset_mid();
    int len;
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rx(ok);
    trig_window(len);
    repeat (5) tick();
    pwm = 1'b1;
    repeat (40) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid busy_before: busy %b, expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({rx, busy, range_valid, range_err} !== 4'b0000 || range_inches !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: rx %b busy %b valid %b err %b range %0d, expected all 0",
               rx, busy, range_valid, range_err, range_inches);
    end
    pwm = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    test_measurement("after_reset", $urandom_range(0, 30), $urandom_range(50, 700));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_no_echo();
    test_long_pulse();
    test_boundaries();
    test_random();
    test_continuous();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
